// File: rtl/sram_pkg.sv
// Shared types and defaults for the async SRAM pin-bus responder.
package sram_pkg;

    localparam int unsigned SRAM_AW = 17;
    localparam int unsigned SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        READ     = 2'd2,
        CONFLICT = 2'd3
    } cycle_class_t;

    // Bus cycle class from the (registered) active-low strobes.
    function automatic cycle_class_t classify(input logic we_n, input logic oe_n);
        cycle_class_t cls;
        case ({we_n, oe_n})
            2'b01:   cls = WRITE;
            2'b10:   cls = READ;
            2'b00:   cls = CONFLICT;
            default: cls = IDLE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/sram_emu_mem.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// No reset so that it maps onto block RAM.
module sram_emu_mem #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [1:0]    we_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned BW    = DW / 2;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    // Byte-lane writes plus read-before-write registered read.
    always_ff @(posedge clk) begin
        if (we_i[1]) mem[addr_i][DW-1:BW] <= wdata_i[DW-1:BW];
        if (we_i[0]) mem[addr_i][BW-1:0]  <= wdata_i[BW-1:0];
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_pin_responder.sv
// Emulates a 128Kx16 async SRAM on the controller's pin bus using on-chip RAM.
// Pins are registered, classified, applied to memory; reads return two edges
// after the pins were sampled. Also flags strobe contention and tracks the
// controller's ascending zero-fill sweep.
module sram_pin_responder
    import sram_pkg::*;
#(
    parameter int unsigned AW    = SRAM_AW,
    parameter int unsigned DW    = SRAM_DW,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    sram_addr,
    input  logic [DW-1:0]    sram_dq_i,
    output logic [DW-1:0]    sram_dq_o,
    output logic [1:0]       sram_dq_oe,
    input  logic             sram_oe_n,
    input  logic             sram_we_n,
    input  logic             sram_ub_n,
    input  logic             sram_lb_n,
    output logic             contention_err,
    output logic             clear_done,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    localparam int unsigned BW = DW / 2;
    localparam logic [AW:0] LAST_WORD = {1'b0, {AW{1'b1}}};

    // Pin stage
    logic [AW-1:0] p_addr_q;
    logic [DW-1:0] p_dq_q;
    logic          p_oe_n_q, p_we_n_q, p_ub_n_q, p_lb_n_q;

    // Read-return stage
    logic          s2_rd_q;
    logic [1:0]    s2_lanes_q;
    logic [DW-1:0] rdata;

    logic [DW-1:0] dq_q;
    logic [1:0]    dq_oe_q;
    logic          contention_q, clear_done_q, clear_done_d;
    logic [AW:0]   sweep_ptr_q, sweep_ptr_d;
    logic [CNT_W-1:0] wr_count_q, rd_count_q;

    cycle_class_t cls;
    logic         is_wr;
    logic [1:0]   mem_we;
    logic [AW:0]  addr_ext;
    logic [DW-1:0] read_word;

    // Register every pin each cycle; strobes park inactive so the first class after reset is IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_addr_q <= '0;
            p_dq_q   <= '0;
            p_oe_n_q <= 1'b1;
            p_we_n_q <= 1'b1;
            p_ub_n_q <= 1'b1;
            p_lb_n_q <= 1'b1;
        end else begin
            p_addr_q <= sram_addr;
            p_dq_q   <= sram_dq_i;
            p_oe_n_q <= sram_oe_n;
            p_we_n_q <= sram_we_n;
            p_ub_n_q <= sram_ub_n;
            p_lb_n_q <= sram_lb_n;
        end
    end

    assign cls      = classify(p_we_n_q, p_oe_n_q);
    assign is_wr    = (cls == WRITE) || (cls == CONFLICT);
    assign mem_we   = {is_wr & ~p_ub_n_q, is_wr & ~p_lb_n_q};
    assign addr_ext = {1'b0, p_addr_q};

    sram_emu_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk     (clk),
        .addr_i  (p_addr_q),
        .wdata_i (p_dq_q),
        .we_i    (mem_we),
        .rdata_o (rdata)
    );

    // Carry the read flag and lane enables alongside the RAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_rd_q    <= 1'b0;
            s2_lanes_q <= '0;
        end else begin
            s2_rd_q    <= (cls == READ);
            s2_lanes_q <= {~p_ub_n_q, ~p_lb_n_q};
        end
    end

    // Masked lanes read back as zero.
    always_comb begin
        read_word          = '0;
        read_word[DW-1:BW] = s2_lanes_q[1] ? rdata[DW-1:BW] : '0;
        read_word[BW-1:0]  = s2_lanes_q[0] ? rdata[BW-1:0]  : '0;
    end

    // Output stage: drive only on read returns, otherwise release lanes and hold data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dq_q    <= '0;
            dq_oe_q <= '0;
        end else if (s2_rd_q) begin
            dq_q    <= read_word;
            dq_oe_q <= s2_lanes_q;
        end else begin
            dq_oe_q <= '0;
        end
    end

    // Sweep tracker: a repeated zero write of the previous word neither advances nor breaks the sweep.
    always_comb begin
        sweep_ptr_d  = sweep_ptr_q;
        clear_done_d = clear_done_q;
        if (is_wr && !clear_done_q) begin
            if ((addr_ext == sweep_ptr_q) && !p_ub_n_q && !p_lb_n_q && (p_dq_q == '0)) begin
                sweep_ptr_d = sweep_ptr_q + (AW+1)'(1);
                if (sweep_ptr_q == LAST_WORD) clear_done_d = 1'b1;
            end else if ((addr_ext == sweep_ptr_q - (AW+1)'(1)) && (p_dq_q == '0)) begin
                sweep_ptr_d = sweep_ptr_q;
            end else begin
                sweep_ptr_d = '0;
            end
        end
    end

    // Sticky flags, sweep pointer and wrapping access counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contention_q <= 1'b0;
            clear_done_q <= 1'b0;
            sweep_ptr_q  <= '0;
            wr_count_q   <= '0;
            rd_count_q   <= '0;
        end else begin
            if (cls == CONFLICT) contention_q <= 1'b1;
            clear_done_q <= clear_done_d;
            sweep_ptr_q  <= sweep_ptr_d;
            if (is_wr)         wr_count_q <= wr_count_q + CNT_W'(1);
            if (cls == READ)   rd_count_q <= rd_count_q + CNT_W'(1);
        end
    end

    assign sram_dq_o      = dq_q;
    assign sram_dq_oe     = dq_oe_q;
    assign contention_err = contention_q;
    assign clear_done     = clear_done_q;
    assign wr_count       = wr_count_q;
    assign rd_count       = rd_count_q;

endmodule
